// File: rtl/mbist_seq_pkg.sv
// Shared definitions for the multi-memory MBIST sequencer.
//   - State encoding of the sequencer FSM (IDLE..FINISH = 0..5).
//   - sel_width(): width of the memory select bus for a given memory count.
package mbist_seq_pkg;

    localparam int unsigned STATE_WIDTH = 3;

    localparam logic [STATE_WIDTH-1:0] IDLE   = 3'd0;
    localparam logic [STATE_WIDTH-1:0] SCAN   = 3'd1;
    localparam logic [STATE_WIDTH-1:0] LAUNCH = 3'd2;
    localparam logic [STATE_WIDTH-1:0] WAIT   = 3'd3;
    localparam logic [STATE_WIDTH-1:0] RECORD = 3'd4;
    localparam logic [STATE_WIDTH-1:0] FINISH = 3'd5;

    typedef enum logic [STATE_WIDTH-1:0] {
        StIdle   = IDLE,
        StScan   = SCAN,
        StLaunch = LAUNCH,
        StWait   = WAIT,
        StRecord = RECORD,
        StFinish = FINISH
    } state_e;

    // A single memory still needs a 1-bit select bus.
    function automatic int unsigned sel_width(input int unsigned num_mem);
        return (num_mem <= 1) ? 1 : $clog2(num_mem);
    endfunction

endpackage

// File: rtl/mbist_timeout_cnt.sv
// Per-memory watchdog counter for the MBIST sequencer.
// Ports:
//   clk, rst_n  clock and synchronous active-low reset
//   clear       zero the counter (takes priority over enable)
//   enable      count up by one per cycle, saturating at all-ones
//   limit       timeout limit; 0 disables expiry
//   expired     registered flag: high while the counter value equals limit-1
module mbist_timeout_cnt #(
    parameter int unsigned TO_WIDTH = 20
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clear,
    input  logic                enable,
    input  logic [TO_WIDTH-1:0] limit,
    output logic                expired
);

    localparam logic [TO_WIDTH-1:0] CNT_MAX = '1;

    logic [TO_WIDTH-1:0] cnt_q, cnt_d;
    logic                expired_q;

    always_comb begin
        cnt_d = cnt_q;
        if (clear) begin
            cnt_d = '0;
        end else if (enable && (cnt_q != CNT_MAX)) begin
            cnt_d = cnt_q + TO_WIDTH'(1);
        end
    end

    // Compare against the next count so that expired lines up with the count
    // it describes; saturation keeps limit = all-ones reachable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q     <= '0;
            expired_q <= 1'b0;
        end else begin
            cnt_q     <= cnt_d;
            expired_q <= (limit != '0) && (cnt_d == (limit - TO_WIDTH'(1)));
        end
    end

    assign expired = expired_q;

endmodule

// File: rtl/mbist_mem_sequencer.sv
// Multi-memory MBIST scheduler between the MBIST engine and the memory mux.
// Walks memories 0..NUM_MEM-1, skips masked ones, launches the engine on each
// enabled memory and records pass/fail/timeout per memory.
// Ports:
//   clk, rst_n              clock and synchronous active-low reset
//   start                   begin a pass (only honoured when idle)
//   mem_enable              per-memory test enable, latched at start
//   stop_on_fail            end the pass at the first failing memory, latched
//   timeout_limit           max WAIT cycles per memory (0 = none), latched
//   engine_done/_error      engine completion and its error flag
//   engine_force_terminate  engine aborted by itself, counts as done + error
//   engine_start            one-cycle launch pulse
//   engine_abort            one-cycle pulse when a memory times out
//   memory_sel              memory routed to the engine
//   busy, done              pass in progress / one-cycle end-of-pass pulse
//   tested_map, fail_map, timeout_map  per-memory results of the last pass
module mbist_mem_sequencer
    import mbist_seq_pkg::*;
#(
    parameter int unsigned NUM_MEM   = 8,
    parameter int unsigned SEL_WIDTH = sel_width(NUM_MEM),
    parameter int unsigned TO_WIDTH  = 20
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic [NUM_MEM-1:0]   mem_enable,
    input  logic                 stop_on_fail,
    input  logic [TO_WIDTH-1:0]  timeout_limit,
    input  logic                 engine_done,
    input  logic                 engine_error,
    input  logic                 engine_force_terminate,
    output logic                 engine_start,
    output logic                 engine_abort,
    output logic [SEL_WIDTH-1:0] memory_sel,
    output logic                 busy,
    output logic                 done,
    output logic [NUM_MEM-1:0]   tested_map,
    output logic [NUM_MEM-1:0]   fail_map,
    output logic [NUM_MEM-1:0]   timeout_map
);

    localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_MEM - 1);

    state_e               state_q, state_d;
    logic [SEL_WIDTH-1:0] idx_q, idx_d;
    logic [NUM_MEM-1:0]   enable_q, enable_d;
    logic                 stop_q, stop_d;
    logic [TO_WIDTH-1:0]  limit_q, limit_d;
    logic                 err_q, err_d;
    logic [SEL_WIDTH-1:0] sel_q, sel_d;
    logic                 start_pulse_q, start_pulse_d;
    logic                 abort_q, abort_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;
    logic [NUM_MEM-1:0]   tested_q, tested_d;
    logic [NUM_MEM-1:0]   fail_q, fail_d;
    logic [NUM_MEM-1:0]   timeout_q, timeout_d;

    logic cnt_clear, cnt_enable, cnt_expired;

    mbist_timeout_cnt #(
        .TO_WIDTH (TO_WIDTH)
    ) u_timeout_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cnt_clear),
        .enable  (cnt_enable),
        .limit   (limit_q),
        .expired (cnt_expired)
    );

    // Outputs are registered: each pulse is set on the edge entering the
    // state in which it must be visible.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        enable_d      = enable_q;
        stop_d        = stop_q;
        limit_d       = limit_q;
        err_d         = err_q;
        sel_d         = sel_q;
        start_pulse_d = 1'b0;
        abort_d       = 1'b0;
        busy_d        = busy_q;
        done_d        = 1'b0;
        tested_d      = tested_q;
        fail_d        = fail_q;
        timeout_d     = timeout_q;
        cnt_clear     = 1'b0;
        cnt_enable    = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    enable_d  = mem_enable;
                    stop_d    = stop_on_fail;
                    limit_d   = timeout_limit;
                    tested_d  = '0;
                    fail_d    = '0;
                    timeout_d = '0;
                    idx_d     = '0;
                    busy_d    = 1'b1;
                    state_d   = StScan;
                end
            end
            StScan: begin
                if (enable_q[idx_q]) begin
                    sel_d           = idx_q;
                    start_pulse_d   = 1'b1;
                    tested_d[idx_q] = 1'b1;
                    state_d         = StLaunch;
                end else if (idx_q == LAST_IDX) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StFinish;
                end else begin
                    idx_d = idx_q + SEL_WIDTH'(1);
                end
            end
            StLaunch: begin
                cnt_clear = 1'b1;
                state_d   = StWait;
            end
            StWait: begin
                cnt_enable = 1'b1;
                // Completion beats a coincident timeout.
                if (engine_done || engine_force_terminate) begin
                    err_d   = engine_error | engine_force_terminate;
                    state_d = StRecord;
                end else if (cnt_expired) begin
                    abort_d          = 1'b1;
                    err_d            = 1'b1;
                    timeout_d[idx_q] = 1'b1;
                    state_d          = StRecord;
                end
            end
            StRecord: begin
                fail_d[idx_q] = err_q;
                if ((err_q && stop_q) || (idx_q == LAST_IDX)) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StFinish;
                end else begin
                    idx_d   = idx_q + SEL_WIDTH'(1);
                    state_d = StScan;
                end
            end
            StFinish: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= StIdle;
            idx_q         <= '0;
            enable_q      <= '0;
            stop_q        <= 1'b0;
            limit_q       <= '0;
            err_q         <= 1'b0;
            sel_q         <= '0;
            start_pulse_q <= 1'b0;
            abort_q       <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            tested_q      <= '0;
            fail_q        <= '0;
            timeout_q     <= '0;
        end else begin
            state_q       <= state_d;
            idx_q         <= idx_d;
            enable_q      <= enable_d;
            stop_q        <= stop_d;
            limit_q       <= limit_d;
            err_q         <= err_d;
            sel_q         <= sel_d;
            start_pulse_q <= start_pulse_d;
            abort_q       <= abort_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            tested_q      <= tested_d;
            fail_q        <= fail_d;
            timeout_q     <= timeout_d;
        end
    end

    assign engine_start = start_pulse_q;
    assign engine_abort = abort_q;
    assign memory_sel   = sel_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign tested_map   = tested_q;
    assign fail_map     = fail_q;
    assign timeout_map  = timeout_q;

endmodule

// File: tb/tb_mbist_mem_sequencer.sv
// Self-checking bench for mbist_mem_sequencer (NUM_MEM = 8).
// A behavioural engine answers each launch after a per-memory latency; the
// expected maps, launch order and pass length come from a per-memory walk.
module tb_mbist_mem_sequencer;

    localparam int NUM_MEM = 8;
    localparam int TO_W    = 20;
    localparam int BOUND   = 3000;

    logic            clk = 1'b0;
    logic            rst_n;
    logic            start;
    logic [7:0]      mem_enable;
    logic            stop_on_fail;
    logic [TO_W-1:0] timeout_limit;
    logic            engine_done;
    logic            engine_error;
    logic            engine_force_terminate;
    logic            engine_start;
    logic            engine_abort;
    logic [2:0]      memory_sel;
    logic            busy;
    logic            done;
    logic [7:0]      tested_map;
    logic [7:0]      fail_map;
    logic [7:0]      timeout_map;

    int n_cmp = 0;
    int n_bad = 0;

    // Engine behaviour per memory: done latency in WAIT cycles, error flag,
    // force-terminate instead of done, or no answer at all.
    int lat   [NUM_MEM];
    bit eerr  [NUM_MEM];
    bit efrc  [NUM_MEM];
    bit never [NUM_MEM];

    mbist_mem_sequencer #(
        .NUM_MEM  (NUM_MEM),
        .TO_WIDTH (TO_W)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .start                  (start),
        .mem_enable             (mem_enable),
        .stop_on_fail           (stop_on_fail),
        .timeout_limit          (timeout_limit),
        .engine_done            (engine_done),
        .engine_error           (engine_error),
        .engine_force_terminate (engine_force_terminate),
        .engine_start           (engine_start),
        .engine_abort           (engine_abort),
        .memory_sel             (memory_sel),
        .busy                   (busy),
        .done                   (done),
        .tested_map             (tested_map),
        .fail_map               (fail_map),
        .timeout_map            (timeout_map)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Engine responder: answers lat+1 cycles after seeing engine_start, so the
    // answer lands in WAIT cycle number lat (counting from 0). Abort cancels.
    initial begin
        int cd;
        int cur;
        cd = 0;
        cur = 0;
        engine_done = 1'b0;
        engine_error = 1'b0;
        engine_force_terminate = 1'b0;
        forever begin
            @(negedge clk);
            engine_done = 1'b0;
            engine_error = 1'b0;
            engine_force_terminate = 1'b0;
            if (rst_n !== 1'b1) begin
                cd = 0;
            end else begin
                if (engine_abort) cd = 0;
                if (cd > 0) begin
                    cd--;
                    if (cd == 0) begin
                        if (efrc[cur]) begin
                            engine_force_terminate = 1'b1;
                        end else begin
                            engine_done  = 1'b1;
                            engine_error = eerr[cur];
                        end
                    end
                end
                if (engine_start) begin
                    cur = int'(memory_sel);
                    cd  = never[cur] ? 0 : lat[cur] + 1;
                end
            end
        end
    end

    task automatic set_all(input int l, input bit e);
        for (int i = 0; i < NUM_MEM; i++) begin
            lat[i] = l; eerr[i] = e; efrc[i] = 1'b0; never[i] = 1'b0;
        end
    endtask

    task automatic run_pass(input logic [7:0] en, input bit sof, input logic [TO_W-1:0] lim,
                            input bit inj, input string name);
        logic [7:0] x_tested, x_fail, x_to;
        int x_len, x_abort, x_starts;
        int x_sel[$];
        int k, got_len, n_start, n_abort, busy_low, t_launch;
        bit fin, resp, e;
        int w;

        // Reference: walk the memories in order, one SCAN cycle each; an
        // enabled one adds LAUNCH + WAIT + RECORD.
        x_tested = '0; x_fail = '0; x_to = '0; x_abort = 0; x_len = 1;
        for (int i = 0; i < NUM_MEM; i++) begin
            x_len++;
            if (en[i]) begin
                resp = !never[i] && (lim == 0 || lat[i] < int'(lim));
                w    = resp ? lat[i] + 1 : int'(lim);
                e    = resp ? (eerr[i] | efrc[i]) : 1'b1;
                x_sel.push_back(i);
                x_tested[i] = 1'b1;
                x_fail[i]   = e;
                if (!resp) begin
                    x_to[i] = 1'b1;
                    x_abort++;
                end
                x_len += 2 + w;
                if (e && sof) break;
            end
        end
        x_starts = x_sel.size();

        mem_enable = en; stop_on_fail = sof; timeout_limit = lim; start = 1'b1;
        k = 0; fin = 1'b0; got_len = 0; n_start = 0; n_abort = 0; busy_low = 0; t_launch = 0;
        while (!fin && k < BOUND) begin
            @(negedge clk);
            k++;
            // A start while busy must be ignored, even with a different mask.
            start = inj && (k == 3);
            if (inj && k == 3) mem_enable = ~en;
            if (engine_abort) begin
                n_abort++;
                check_eq({name, "_abort_delay"}, k - t_launch, int'(lim) + 1);
            end
            if (engine_start) begin
                n_start++;
                t_launch = k;
                if (x_sel.size() > 0) check_eq({name, "_launch_sel"}, memory_sel, x_sel.pop_front());
            end
            if (done) begin
                fin = 1'b1;
                got_len = k;
                check_eq({name, "_busy_at_done"}, busy, 1'b0);
            end else if (!busy) begin
                busy_low++;
            end
        end
        start = 1'b0;
        check_eq({name, "_done_seen"}, fin, 1'b1);
        if (!fin) begin
            rst_n = 1'b0;
            @(negedge clk);
            rst_n = 1'b1;
            return;
        end
        check_eq({name, "_pass_len"}, got_len, x_len);
        check_eq({name, "_tested_map"}, tested_map, x_tested);
        check_eq({name, "_fail_map"}, fail_map, x_fail);
        check_eq({name, "_timeout_map"}, timeout_map, x_to);
        check_eq({name, "_starts"}, n_start, x_starts);
        check_eq({name, "_aborts"}, n_abort, x_abort);
        check_eq({name, "_busy_gaps"}, busy_low, 0);
        @(negedge clk);
        check_eq({name, "_done_one_cycle"}, {done, busy}, 2'b00);
        check_eq({name, "_maps_hold"}, {tested_map, fail_map, timeout_map}, {x_tested, x_fail, x_to});
    endtask

    task automatic reset_mid_pass();
        int k, bad;
        bit seen;
        set_all(20, 1'b0);
        mem_enable = 8'hFF; stop_on_fail = 1'b0; timeout_limit = '0; start = 1'b1;
        k = 0; seen = 1'b0;
        while (!seen && k < BOUND) begin
            @(negedge clk);
            k++;
            start = 1'b0;
            if (engine_start && memory_sel == 3'd4) seen = 1'b1;
        end
        check_eq("rst_reached_mem4", seen, 1'b1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_eq("rst_outputs_zero",
                 {engine_start, engine_abort, memory_sel, busy, done,
                  tested_map, fail_map, timeout_map}, '0);
        rst_n = 1'b1;
        bad = 0;
        repeat (25) begin
            @(negedge clk);
            if (done || engine_abort || busy || engine_start) bad++;
        end
        check_eq("rst_stays_idle", bad, 0);
    endtask

    initial begin
        rst_n = 1'b0; start = 1'b0; mem_enable = '0; stop_on_fail = 1'b0; timeout_limit = '0;
        set_all(10, 1'b0);
        repeat (3) @(negedge clk);
        check_eq("reset_state",
                 {engine_start, engine_abort, memory_sel, busy, done,
                  tested_map, fail_map, timeout_map}, '0);
        rst_n = 1'b1;
        @(negedge clk);

        // Two memories, clean pass.
        set_all(10, 1'b0);
        run_pass(8'b0000_0101, 1'b0, '0, 1'b0, "two_mem");

        // Error on memory 3 with stop_on_fail.
        set_all(4, 1'b0);
        eerr[3] = 1'b1;
        run_pass(8'hFF, 1'b1, '0, 1'b0, "stop_fail");

        // Memory 1 never answers, timeout 16.
        set_all(10, 1'b0);
        never[1] = 1'b1;
        run_pass(8'h03, 1'b0, 20'd16, 1'b0, "timeout");

        // Done on exactly the timeout cycle (with error), then one cycle late.
        set_all(15, 1'b1);
        run_pass(8'h01, 1'b0, 20'd16, 1'b0, "done_at_limit");
        set_all(16, 1'b0);
        run_pass(8'h01, 1'b0, 20'd16, 1'b0, "done_after_limit");

        // Force-terminate counts as failure.
        set_all(2, 1'b0);
        efrc[5] = 1'b1;
        run_pass(8'h60, 1'b0, '0, 1'b0, "force_term");

        // Empty mask with a start injected while busy.
        run_pass(8'h00, 1'b0, '0, 1'b1, "empty");

        reset_mid_pass();
        set_all(3, 1'b0);
        run_pass(8'h11, 1'b0, '0, 1'b0, "after_reset");

        for (int p = 0; p < 25; p++) begin
            logic [TO_W-1:0] lim;
            lim = ($urandom_range(0, 3) == 0) ? '0 : TO_W'($urandom_range(1, 24));
            for (int i = 0; i < NUM_MEM; i++) begin
                lat[i]   = int'($urandom_range(0, 20));
                eerr[i]  = ($urandom_range(0, 3) == 0);
                efrc[i]  = ($urandom_range(0, 7) == 0);
                never[i] = (lim != 0) && ($urandom_range(0, 5) == 0);
            end
            run_pass(8'($urandom), 1'($urandom), lim, 1'($urandom), $sformatf("rand%0d", p));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
